link_egress: RTL

- Rate-limited egress link model at the dequeue side of the AQM queue. It consumes the AQM's outgoing packet and drop flag, and produces the link-ready handshake back to the AQM.
- It serializes each non-dropped packet for a size-dependent number of cycles, and it discards dropped packets in zero cycles.
- It keeps delivered, dropped and byte statistics for benches and for the system-level throughput and delay measurements.

---
 rtl/link_egress_pkg.sv | 29 ++
 rtl/link_egress_sat_counter.sv | 33 +++
 rtl/link_egress.sv | 121 ++++++++++++
 3 files changed

// File: rtl/link_egress_pkg.sv
// Shared types and constants for the egress link model: packet layout, FSM states,
// default rate/counter widths and the serialization-length helper.
package link_egress_pkg;

   localparam int unsigned PKT_SIZE_W          = 16;
   localparam int unsigned BYTES_PER_CYCLE_DEF = 1;
   localparam int unsigned STAT_CTR_W          = 32;

   typedef struct packed {
      logic                  valid;
      logic [PKT_SIZE_W-1:0] size;
   } Packet;

   typedef enum logic {
      IDLE,
      TX
   } EgressState;

   // ceil(size / 2**shift), never less than one cycle
   function automatic logic [PKT_SIZE_W-1:0] ser_cycles(input logic [PKT_SIZE_W-1:0] size,
                                                        input int unsigned shift);
      logic [PKT_SIZE_W-1:0] mask;
      logic [PKT_SIZE_W-1:0] cycles;
      mask   = PKT_SIZE_W'((32'd1 << shift) - 32'd1);
      cycles = (size >> shift) + PKT_SIZE_W'(|(size & mask));
      return (cycles == '0) ? PKT_SIZE_W'(1) : cycles;
   endfunction

endpackage

// File: rtl/link_egress_sat_counter.sv
// Saturating up-counter: adds i__amount when i__en is high and sticks at all-ones.
module link_egress_sat_counter #(
   parameter int unsigned W     = 32,
   parameter int unsigned AMT_W = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i__en,
   input  logic [AMT_W-1:0] i__amount,
   output logic [W-1:0]     o__count
);

   // Wide enough that neither operand is truncated before the overflow test
   localparam int unsigned SUM_W = ((W > AMT_W) ? W : AMT_W) + 1;

   logic [W-1:0]     r_count;
   logic [SUM_W-1:0] w_sum;
   logic             w_ovf;

   assign w_sum = SUM_W'(r_count) + SUM_W'(i__amount);
   assign w_ovf = w_sum > SUM_W'({W{1'b1}});

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i__en) begin
         r_count <= w_ovf ? '1 : w_sum[W-1:0];
      end
   end

   assign o__count = r_count;

endmodule

// File: rtl/link_egress.sv
// Rate-limited egress link: serializes accepted packets, discards dropped ones, keeps stats.
// Optional link pause input is enabled by defining LINK_EGRESS_PAUSE_EN.
module link_egress
   import link_egress_pkg::*;
#(
   parameter int unsigned BYTES_PER_CYCLE = BYTES_PER_CYCLE_DEF,
   parameter int unsigned SIZE_W          = PKT_SIZE_W,
   parameter int unsigned CTR_W           = STAT_CTR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  Packet            i__packet,
   input  logic             i__drop_packet,
`ifdef LINK_EGRESS_PAUSE_EN
   input  logic             i__pause,
`endif
   output logic             o__link_ready,
   output logic             o__tx_start,
   output logic             o__tx_done,
   output Packet            o__tx_packet,
   output logic [CTR_W-1:0] o__delivered_count,
   output logic [CTR_W-1:0] o__dropped_count,
   output logic [CTR_W-1:0] o__byte_count,
   output logic             o__proto_err
);

   localparam int unsigned SHIFT = $clog2(BYTES_PER_CYCLE);

   EgressState        r_state, w_state_next;
   logic [SIZE_W-1:0] r_remaining, w_remaining_next;
   Packet             r_tx_packet, w_tx_packet_next;
   logic              r_proto_err;
   logic              w_paused, w_last, w_done;
   logic              w_accept, w_accept_tx, w_accept_drop;

`ifdef LINK_EGRESS_PAUSE_EN
   assign w_paused = i__pause;
`else
   assign w_paused = 1'b0;
`endif

   assign w_last        = (r_remaining == SIZE_W'(1));
   // Ready in the last TX cycle so back-to-back packets leave no idle gap
   assign o__link_ready = !w_paused && ((r_state == IDLE) || w_last);
   assign w_done        = (r_state == TX) && w_last && !w_paused;
   assign w_accept      = i__packet.valid && o__link_ready;
   assign w_accept_tx   = w_accept && !i__drop_packet;
   assign w_accept_drop = w_accept && i__drop_packet;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_remaining <= '0;
         r_tx_packet <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_remaining <= w_remaining_next;
         r_tx_packet <= w_tx_packet_next;
         r_proto_err <= r_proto_err | (i__packet.valid & ~o__link_ready);
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_remaining_next = r_remaining;
      w_tx_packet_next = r_tx_packet;
      if (w_accept_tx) begin
         w_state_next     = TX;
         w_remaining_next = SIZE_W'(ser_cycles(i__packet.size, SHIFT));
         w_tx_packet_next = i__packet;
      end else if ((r_state == TX) && !w_paused) begin
         if (w_last) begin
            w_state_next     = IDLE;
            w_remaining_next = '0;
            w_tx_packet_next = '0;
         end else begin
            w_remaining_next = r_remaining - SIZE_W'(1);
         end
      end
   end

   assign o__tx_start  = w_accept_tx;
   assign o__tx_done   = w_done;
   assign o__tx_packet = r_tx_packet;
   assign o__proto_err = r_proto_err;

   link_egress_sat_counter #(
      .W     (CTR_W),
      .AMT_W (1)
   ) u_delivered (
      .clk       (clk),
      .reset     (reset),
      .i__en     (w_done),
      .i__amount (1'b1),
      .o__count  (o__delivered_count)
   );

   link_egress_sat_counter #(
      .W     (CTR_W),
      .AMT_W (1)
   ) u_dropped (
      .clk       (clk),
      .reset     (reset),
      .i__en     (w_accept_drop),
      .i__amount (1'b1),
      .o__count  (o__dropped_count)
   );

   link_egress_sat_counter #(
      .W     (CTR_W),
      .AMT_W (SIZE_W)
   ) u_bytes (
      .clk       (clk),
      .reset     (reset),
      .i__en     (w_done),
      .i__amount (SIZE_W'(r_tx_packet.size)),
      .o__count  (o__byte_count)
   );

endmodule
